// File: rtl/scr1_ipic_nested_if.sv
// CSR-side register bus of the nested IPIC: read/write strobes, address, write and read data.
// master = CSR unit, slave = interrupt controller.
interface scr1_ipic_nested_if;
    logic        csr2ipic_r_req;
    logic        csr2ipic_w_req;
    logic [3:0]  csr2ipic_addr;
    logic [31:0] csr2ipic_wdata;
    logic [31:0] ipic2csr_rdata;

    modport master (
        output csr2ipic_r_req,
        output csr2ipic_w_req,
        output csr2ipic_addr,
        output csr2ipic_wdata,
        input  ipic2csr_rdata
    );

    modport slave (
        input  csr2ipic_r_req,
        input  csr2ipic_w_req,
        input  csr2ipic_addr,
        input  csr2ipic_wdata,
        output ipic2csr_rdata
    );
endinterface

// File: rtl/scr1_ipic_nested.sv
// Nested-preemption interrupt controller: synchronised IRQ lines, per-line priority, threshold
// and an in-service nest (ISVR/CISV) driving the machine external interrupt request.
module scr1_ipic_nested #(
    parameter int unsigned IRQ_NUM     = 16,
    parameter int unsigned PRIO_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_NUM-1:0]   soc2ipic_irq_lines_i,
    scr1_ipic_nested_if.slave    csr_if,
    output logic                 ipic2csr_irq_m_req_o
);

    localparam int unsigned IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
    localparam logic [IDX_W:0] CisvVoid = (IDX_W+1)'(IRQ_NUM);

    localparam logic [3:0] AddrCisv  = 4'd0;
    localparam logic [3:0] AddrCicsr = 4'd1;
    localparam logic [3:0] AddrIpr   = 4'd2;
    localparam logic [3:0] AddrIsvr  = 4'd3;
    localparam logic [3:0] AddrEoi   = 4'd4;
    localparam logic [3:0] AddrSoi   = 4'd5;
    localparam logic [3:0] AddrIdx   = 4'd6;
    localparam logic [3:0] AddrIcsr  = 4'd7;
    localparam logic [3:0] AddrIprio = 4'd8;
    localparam logic [3:0] AddrThr   = 4'd9;

    // Returns {found, index}: highest priority request, ties to the lowest index.
    function automatic logic [IDX_W:0] arb_pick(
        input logic [IRQ_NUM-1:0]             req,
        input logic [IRQ_NUM-1:0][PRIO_W-1:0] prio
    );
        logic              found;
        logic [IDX_W-1:0]  idx;
        logic [PRIO_W-1:0] best;
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int unsigned i = 0; i < IRQ_NUM; i++) begin
            if (req[i] && (!found || prio[i] > best)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
                best  = prio[i];
            end
        end
        return {found, idx};
    endfunction

    logic [SYNC_STAGES-1:0][IRQ_NUM-1:0] sync_q;
    logic [IRQ_NUM-1:0]                  dly_q;
    logic [IRQ_NUM-1:0]                  ipr_q, ipr_d;
    logic [IRQ_NUM-1:0]                  isvr_q, isvr_d;
    logic [IRQ_NUM-1:0]                  ier_q, imr_q, invr_q;
    logic [IRQ_NUM-1:0][PRIO_W-1:0]      iprio_q;
    logic [PRIO_W-1:0]                   thr_q;
    logic [IDX_W-1:0]                    idx_q;
    logic [IDX_W:0]                      cisv_q, cisv_d;

    logic [IRQ_NUM-1:0] sync_lines, lvl, edge_act, clr;
    logic [31:0]        wdata;
    logic [3:0]         addr;
    logic               wr_cicsr, wr_ipr, wr_eoi, wr_soi, wr_idx, wr_icsr, wr_iprio, wr_thr;
    logic               cisv_vld, idx_vld;
    logic [IDX_W-1:0]   cisv_idx;
    logic [IRQ_NUM-1:0] cisv_onehot;
    logic [IDX_W:0]     win_pick, nest_pick;
    logic               win_vld, nest_vld;
    logic [IDX_W-1:0]   win_idx, nest_idx;
    logic [PRIO_W-1:0]  win_prio, cisv_prio;
    logic               req_vd, irq_req;
    logic               unused_wdata;

    assign wdata        = csr_if.csr2ipic_wdata;
    assign addr         = csr_if.csr2ipic_addr;
    assign unused_wdata = ^wdata;

    assign wr_cicsr = csr_if.csr2ipic_w_req && (addr == AddrCicsr);
    assign wr_ipr   = csr_if.csr2ipic_w_req && (addr == AddrIpr);
    assign wr_eoi   = csr_if.csr2ipic_w_req && (addr == AddrEoi);
    assign wr_soi   = csr_if.csr2ipic_w_req && (addr == AddrSoi);
    assign wr_idx   = csr_if.csr2ipic_w_req && (addr == AddrIdx);
    assign wr_icsr  = csr_if.csr2ipic_w_req && (addr == AddrIcsr);
    assign wr_iprio = csr_if.csr2ipic_w_req && (addr == AddrIprio);
    assign wr_thr   = csr_if.csr2ipic_w_req && (addr == AddrThr);

    assign cisv_vld    = cisv_q < CisvVoid;
    assign cisv_idx    = cisv_q[IDX_W-1:0];
    assign idx_vld     = {1'b0, idx_q} < CisvVoid;
    assign cisv_onehot = cisv_vld ? (IRQ_NUM'(1) << cisv_idx) : '0;

    // Input synchroniser followed by the edge-detect delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q[0] <= soc2ipic_irq_lines_i;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_lines = sync_q[SYNC_STAGES-1];
    assign lvl        = sync_lines ^ invr_q;
    assign edge_act   = (sync_lines ^ dly_q) & lvl;

    assign win_pick  = arb_pick(ipr_q & ier_q, iprio_q);
    assign win_vld   = win_pick[IDX_W];
    assign win_idx   = win_pick[IDX_W-1:0];
    assign win_prio  = iprio_q[win_idx];
    assign cisv_prio = iprio_q[cisv_idx];

    assign nest_pick = arb_pick(isvr_q & ~cisv_onehot, iprio_q);
    assign nest_vld  = nest_pick[IDX_W];
    assign nest_idx  = nest_pick[IDX_W-1:0];

    // Equal priority never preempts the line in service
    assign req_vd  = win_vld && (win_prio > thr_q);
    assign irq_req = req_vd && (!cisv_vld || (win_prio > cisv_prio));
    assign ipic2csr_irq_m_req_o = irq_req;

    always_comb begin
        clr = '0;
        if (wr_ipr) begin
            clr = wdata[IRQ_NUM-1:0];
        end
        if (wr_cicsr && cisv_vld && wdata[0]) begin
            clr[cisv_idx] = 1'b1;
        end
        if (wr_icsr && idx_vld && wdata[0]) begin
            clr[idx_q] = 1'b1;
        end
        if (wr_soi && irq_req) begin
            clr[win_idx] = 1'b1;
        end
    end

    // Level lines follow lvl (a clear only lands when lvl is already low); in edge mode a
    // fresh edge wins over a simultaneous clear.
    assign ipr_d = (imr_q & (edge_act | (ipr_q & ~clr))) | (~imr_q & lvl);

    always_comb begin
        isvr_d = isvr_q;
        cisv_d = cisv_q;
        if (wr_soi && irq_req) begin
            isvr_d[win_idx] = 1'b1;
            cisv_d          = {1'b0, win_idx};
        end else if (wr_eoi && cisv_vld) begin
            isvr_d[cisv_idx] = 1'b0;
            cisv_d           = nest_vld ? {1'b0, nest_idx} : CisvVoid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ipr_q  <= '0;
            isvr_q <= '0;
            cisv_q <= CisvVoid;
        end else begin
            ipr_q  <= ipr_d;
            isvr_q <= isvr_d;
            cisv_q <= cisv_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ier_q  <= '0;
            imr_q  <= '0;
            invr_q <= '0;
            thr_q  <= '0;
            idx_q  <= '0;
            for (int unsigned i = 0; i < IRQ_NUM; i++) begin
                iprio_q[i] <= PRIO_W'(1);
            end
        end else begin
            if (wr_cicsr && cisv_vld) begin
                ier_q[cisv_idx] <= wdata[1];
            end
            if (wr_icsr && idx_vld) begin
                ier_q[idx_q]  <= wdata[1];
                imr_q[idx_q]  <= wdata[2];
                invr_q[idx_q] <= wdata[3];
            end
            if (wr_iprio && idx_vld) begin
                iprio_q[idx_q] <= wdata[PRIO_W-1:0];
            end
            if (wr_thr) begin
                thr_q <= wdata[PRIO_W-1:0];
            end
            if (wr_idx) begin
                idx_q <= wdata[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        csr_if.ipic2csr_rdata = '0;
        if (csr_if.csr2ipic_r_req) begin
            case (addr)
                AddrCisv:  csr_if.ipic2csr_rdata = 32'(cisv_q);
                AddrCicsr: begin
                    if (cisv_vld) begin
                        csr_if.ipic2csr_rdata[0] = ipr_q[cisv_idx];
                        csr_if.ipic2csr_rdata[1] = ier_q[cisv_idx];
                    end
                end
                AddrIpr:   csr_if.ipic2csr_rdata = 32'(ipr_q);
                AddrIsvr:  csr_if.ipic2csr_rdata = 32'(isvr_q);
                AddrIdx:   csr_if.ipic2csr_rdata = 32'(idx_q);
                AddrIcsr: begin
                    csr_if.ipic2csr_rdata[12 +: IDX_W] = idx_q;
                    if (idx_vld) begin
                        csr_if.ipic2csr_rdata[0]   = ipr_q[idx_q];
                        csr_if.ipic2csr_rdata[1]   = ier_q[idx_q];
                        csr_if.ipic2csr_rdata[2]   = imr_q[idx_q];
                        csr_if.ipic2csr_rdata[3]   = invr_q[idx_q];
                        csr_if.ipic2csr_rdata[4]   = isvr_q[idx_q];
                        csr_if.ipic2csr_rdata[9:8] = 2'b11;
                    end
                end
                AddrIprio: begin
                    if (idx_vld) begin
                        csr_if.ipic2csr_rdata = 32'(iprio_q[idx_q]);
                    end
                end
                AddrThr:   csr_if.ipic2csr_rdata = 32'(thr_q);
                default:   csr_if.ipic2csr_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_ipic_nested.sv
// Scoreboard bench for scr1_ipic_nested: directed scenarios plus random CSR traffic, checked
// against a behavioural model of the pending/nesting rules.
module tb_scr1_ipic_nested;

    localparam int unsigned N    = 16;
    localparam int unsigned PW   = 3;
    localparam int unsigned SS   = 2;
    localparam int unsigned IW   = 4;
    localparam int          VOID = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw   = '0;
    logic         irq;

    scr1_ipic_nested_if csr_if ();

    scr1_ipic_nested #(
        .IRQ_NUM     (N),
        .PRIO_W      (PW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .soc2ipic_irq_lines_i (raw),
        .csr_if               (csr_if),
        .ipic2csr_irq_m_req_o (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic [31:0] rd;
        logic [3:0]  a;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    bit   running = 1'b0;

    // Model state; m_hist[0] is the most recently sampled raw vector
    logic [N-1:0] m_pend, m_ie, m_im, m_inv, m_isv;
    int           m_prio[N];
    int           m_thr, m_idx, m_cisv;
    logic [N-1:0] m_hist[$];

    function automatic void model_reset();
        m_pend = '0; m_ie = '0; m_im = '0; m_inv = '0; m_isv = '0;
        for (int i = 0; i < N; i++) m_prio[i] = 1;
        m_thr  = 0;
        m_idx  = 0;
        m_cisv = VOID;
        m_hist.delete();
        for (int i = 0; i <= SS; i++) m_hist.push_back('0);
    endfunction

    // Scan priorities from the top down, lowest index first
    function automatic int pick(input logic [N-1:0] req);
        for (int p = (1 << PW) - 1; p >= 0; p--)
            for (int i = 0; i < N; i++)
                if (req[i] && m_prio[i] == p) return i;
        return -1;
    endfunction

    function automatic bit m_irq();
        int w = pick(m_pend & m_ie);
        if (w < 0) return 1'b0;
        if (m_prio[w] <= m_thr) return 1'b0;
        if (m_cisv == VOID) return 1'b1;
        return m_prio[w] > m_prio[m_cisv];
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            4'd0: v = 32'(m_cisv);
            4'd1: if (m_cisv != VOID) v = {30'd0, m_ie[m_cisv], m_pend[m_cisv]};
            4'd2: v = 32'(m_pend);
            4'd3: v = 32'(m_isv);
            4'd6: v = 32'(m_idx);
            4'd7: begin
                v = 32'(m_idx) << 12;
                if (m_idx < N)
                    v = v | 32'h300 | (32'(m_isv[m_idx]) << 4) | (32'(m_inv[m_idx]) << 3)
                        | (32'(m_im[m_idx]) << 2) | (32'(m_ie[m_idx]) << 1) | 32'(m_pend[m_idx]);
            end
            4'd8: if (m_idx < N) v = 32'(m_prio[m_idx]);
            4'd9: v = 32'(m_thr);
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void model_step(input bit w, input logic [3:0] a, input logic [31:0] d,
                                       input logic [N-1:0] raw_now);
        int           win  = pick(m_pend & m_ie);
        bit           go   = m_irq();
        logic [N-1:0] sync = m_hist[SS-1];
        logic [N-1:0] dly  = m_hist[SS];
        logic [N-1:0] clr  = '0;
        int           nxt;
        if (w) begin
            case (a)
                4'd1: if (m_cisv != VOID && d[0]) clr[m_cisv] = 1'b1;
                4'd2: clr = d[N-1:0];
                4'd5: if (go) clr[win] = 1'b1;
                4'd7: if (m_idx < N && d[0]) clr[m_idx] = 1'b1;
                default: ;
            endcase
        end
        for (int i = 0; i < N; i++) begin
            bit lv = sync[i] ^ m_inv[i];
            bit ed = (sync[i] != dly[i]) && lv;
            if (m_im[i]) begin
                if (ed) m_pend[i] = 1'b1;
                else if (clr[i]) m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = lv;   // a clear can only land when the level is already low
            end
        end
        if (w) begin
            case (a)
                4'd1: if (m_cisv != VOID) m_ie[m_cisv] = d[1];
                4'd4: if (m_cisv != VOID) begin
                    m_isv[m_cisv] = 1'b0;
                    nxt = pick(m_isv);
                    m_cisv = (nxt < 0) ? VOID : nxt;
                end
                4'd5: if (go) begin
                    m_isv[win] = 1'b1;
                    m_cisv = win;
                end
                4'd6: m_idx = int'(d[IW-1:0]);
                4'd7: if (m_idx < N) begin
                    m_ie[m_idx]  = d[1];
                    m_im[m_idx]  = d[2];
                    m_inv[m_idx] = d[3];
                end
                4'd8: if (m_idx < N) m_prio[m_idx] = int'(d[PW-1:0]);
                4'd9: m_thr = int'(d[PW-1:0]);
                default: ;
            endcase
        end
        m_hist.push_front(raw_now);
        void'(m_hist.pop_back());
    endfunction

    // One bus cycle: drive, push the expectation, advance the model at the clock edge
    task automatic issue(input bit r, input bit w, input logic [3:0] a, input logic [31:0] d,
                         input bit use_c, input logic [31:0] c_rd, input bit c_irq);
        exp_t e;
        csr_if.csr2ipic_r_req = r;
        csr_if.csr2ipic_w_req = w;
        csr_if.csr2ipic_addr  = a;
        csr_if.csr2ipic_wdata = d;
        e.a   = a;
        e.irq = use_c ? c_irq : m_irq();
        e.rd  = r ? (use_c ? c_rd : model_read(a)) : 32'd0;
        sb.push_back(e);
        @(posedge clk);
        if (rst_n) model_step(w, a, d, raw);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        issue(1'b0, 1'b1, a, d, 1'b0, 32'd0, 1'b0);
    endtask
    task automatic rd(input logic [3:0] a);
        issue(1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask
    task automatic chk(input logic [3:0] a, input logic [31:0] v, input bit i);
        issue(1'b1, 1'b0, a, 32'd0, 1'b1, v, i);
    endtask
    task automatic pulse(input logic [N-1:0] m);
        raw = raw | m;
        idle(1);
        raw = raw & ~m;
        idle(3);
    endtask
    task automatic cfg(input int line, input logic [31:0] icsr, input int prio);
        wr(4'd6, 32'(line));
        wr(4'd7, icsr);
        wr(4'd8, 32'(prio));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq_m_req t=%0t addr=%0d got %b want %b", $time, e.a, irq, e.irq);
                end
                n_chk++;
                if (csr_if.ipic2csr_rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL rdata t=%0t addr=%0d got %h want %h", $time, e.a,
                             csr_if.ipic2csr_rdata, e.rd);
                end
            end else if (running) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard t=%0t got empty want entry", $time);
            end
        end
    end

    initial begin
        logic [3:0] waddr[15] = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7,
                                  4'd7, 4'd8, 4'd8, 4'd9, 4'd12};
        int sel;
        csr_if.csr2ipic_r_req = 1'b0;
        csr_if.csr2ipic_w_req = 1'b0;
        csr_if.csr2ipic_addr  = '0;
        csr_if.csr2ipic_wdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        running = 1'b1;
        chk(4'd0, 32'd16, 1'b0);
        rst_n = 1'b1;
        chk(4'd2, 32'd0, 1'b0);
        chk(4'd3, 32'd0, 1'b0);
        chk(4'd8, 32'd1, 1'b0);
        chk(4'd9, 32'd0, 1'b0);
        chk(4'd7, 32'h300, 1'b0);
        chk(4'd12, 32'd0, 1'b0);

        // Edge line 3: latency and SOI
        cfg(3, 32'h6, 2);
        raw[3] = 1'b1;
        idle(1);
        raw[3] = 1'b0;
        idle(1);
        chk(4'd2, 32'h0, 1'b0);
        chk(4'd2, 32'h8, 1'b1);
        wr(4'd5, 32'd0);
        chk(4'd0, 32'd3, 1'b0);
        chk(4'd3, 32'h8, 1'b0);
        chk(4'd2, 32'h0, 1'b0);
        wr(4'd4, 32'd0);
        chk(4'd0, 32'd16, 1'b0);

        // Nesting 5 (prio 2) under 9 (prio 4)
        cfg(5, 32'h6, 2);
        cfg(9, 32'h6, 4);
        pulse(16'h0020);
        wr(4'd5, 32'd0);
        chk(4'd0, 32'd5, 1'b0);
        pulse(16'h0200);
        chk(4'd0, 32'd5, 1'b1);
        wr(4'd5, 32'd0);
        chk(4'd0, 32'd9, 1'b0);
        chk(4'd3, 32'h220, 1'b0);
        wr(4'd4, 32'd0);
        chk(4'd0, 32'd5, 1'b0);
        chk(4'd3, 32'h20, 1'b0);
        wr(4'd4, 32'd0);
        chk(4'd0, 32'd16, 1'b0);
        chk(4'd3, 32'h0, 1'b0);

        // Equal priorities: lowest index wins, no preemption
        cfg(2, 32'h6, 3);
        cfg(7, 32'h6, 3);
        pulse(16'h0084);
        chk(4'd2, 32'h84, 1'b1);
        wr(4'd5, 32'd0);
        chk(4'd0, 32'd2, 1'b0);
        chk(4'd2, 32'h80, 1'b0);
        wr(4'd4, 32'd0);
        chk(4'd0, 32'd16, 1'b1);
        wr(4'd2, 32'h80);
        chk(4'd2, 32'h0, 1'b0);

        // Threshold
        cfg(4, 32'h6, 2);
        wr(4'd9, 32'd2);
        pulse(16'h0010);
        chk(4'd2, 32'h10, 1'b0);
        wr(4'd9, 32'd1);
        chk(4'd9, 32'd1, 1'b1);
        wr(4'd2, 32'h10);
        wr(4'd9, 32'd0);

        // Level mode, inverted line 0
        cfg(0, 32'hA, 1);
        idle(1);
        chk(4'd2, 32'h1, 1'b1);
        wr(4'd2, 32'h1);
        chk(4'd2, 32'h1, 1'b1);
        raw[0] = 1'b1;
        idle(3);
        chk(4'd2, 32'h0, 1'b0);
        cfg(0, 32'h0, 1);
        raw[0] = 1'b0;
        idle(3);

        // Edge arriving with a W1C on line 6
        cfg(6, 32'h6, 1);
        raw[6] = 1'b1;
        idle(1);
        raw[6] = 1'b0;
        idle(1);
        wr(4'd2, 32'h40);
        chk(4'd2, 32'h40, 1'b1);

        // Build a nest 6 -> 9, then reset mid-nest
        wr(4'd5, 32'd0);
        pulse(16'h0200);
        wr(4'd5, 32'd0);
        chk(4'd3, 32'h240, 1'b0);
        rst_n = 1'b0;
        model_reset();
        chk(4'd0, 32'd16, 1'b0);
        chk(4'd3, 32'h0, 1'b0);
        chk(4'd2, 32'h0, 1'b0);
        rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            raw = raw ^ (N'($urandom) & N'($urandom) & N'($urandom));
            sel = $urandom_range(0, 9);
            if (sel < 4) rd(4'($urandom_range(0, 15)));
            else if (sel < 7) wr(waddr[$urandom_range(0, 14)], $urandom);
            else idle(1);
        end
        running = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
